// File: rtl/spinner_pkg.sv
// Shared types and helpers for the spinner quadrature path.
//   quad_phase_t : {a,b} phase pair
//   PHASE_IDLE   : phase assumed at reset (both lines high)
//   quad_dir()   : classifies a phase transition as {valid, illegal, inc}.
//                  The emulated encoder generator uses the same function, so
//                  both ends agree on which rotation counts upward.
package spinner_pkg;

    typedef logic [1:0] quad_phase_t;

    localparam quad_phase_t PHASE_IDLE = 2'b11;

    typedef struct packed {
        logic valid;    // single-bit Gray step
        logic illegal;  // both bits changed at once
        logic inc;      // direction of a valid step
    } quad_dec_t;

    function automatic quad_dec_t quad_dir(input quad_phase_t prev_ph,
                                           input quad_phase_t new_ph);
        quad_dec_t r;
        r = '0;
        case ({prev_ph, new_ph})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                r.valid = 1'b1;
                r.inc   = 1'b1;
            end
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                r.valid = 1'b1;
            end
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                r.illegal = 1'b1;
            end
            default: ;  // no change
        endcase
        return r;
    endfunction

endpackage

// File: rtl/spinner_quad_decoder_filter.sv
// quad_glitch_filter: 2-flop synchronizer followed by a stability filter.
//   clk, rst  : clock, async active-high reset
//   ce        : sample enable for the filter (synchronizer always runs)
//   din       : asynchronous input vector
//   filt      : last accepted value
//   sync_val  : current synchronized value (the one being accepted)
//   upd       : combinational strobe, high on the ce cycle where sync_val
//               replaces filt; the caller decodes {filt, sync_val} then.
module quad_glitch_filter #(
    parameter int             W        = 2,
    parameter int             FILT_LEN = 3,
    parameter logic [W-1:0]   RST_VAL  = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] din,
    output logic [W-1:0] filt,
    output logic [W-1:0] sync_val,
    output logic         upd
);

    localparam logic [3:0] FCNT_LAST = 4'(FILT_LEN - 1);

    logic [W-1:0] meta_q, sync_q;
    logic [W-1:0] cand_q, cand_d;
    logic [W-1:0] filt_q, filt_d;
    logic [3:0]   fcnt_q, fcnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            cand_q <= RST_VAL;
            filt_q <= RST_VAL;
            fcnt_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            cand_q <= cand_d;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    always_comb begin
        cand_d = cand_q;
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        upd    = 1'b0;
        if (ce) begin
            if (sync_q != cand_q) begin
                // New candidate restarts the stability count.
                cand_d = sync_q;
                fcnt_d = '0;
            end else if (sync_q != filt_q && fcnt_q == FCNT_LAST) begin
                filt_d = sync_q;
                upd    = 1'b1;
            end else if (fcnt_q != 4'hF) begin
                fcnt_d = fcnt_q + 4'd1;
            end
        end
    end

    assign filt     = filt_q;
    assign sync_val = sync_q;

endmodule

// File: rtl/spinner_quad_decoder.sv
// spinner_quad_decoder: quadrature AB decoder with wrapping position counter.
//   clk_12m, reset : clock, async active-high reset
//   ce             : sample enable (filter/decoder advance only when high)
//   enc_a, enc_b   : asynchronous encoder phases
//   clr            : synchronous count clear, independent of ce
//   count          : position, modulo 2^CNT_W
//   dir            : direction of last counted step (1 = up)
//   step, err      : one-clk pulses for a counted step / illegal transition
// Optional build macro QUAD_VELOCITY_EN adds vel[7:0], the signed number of
// counted steps during the previous 2^16-ce window.
import spinner_pkg::*;

module spinner_quad_decoder #(
    parameter int CNT_W     = 8,
    parameter int FILT_LEN  = 3,
    parameter int DIV_SHIFT = 0
) (
    input  logic             clk_12m,
    input  logic             reset,
    input  logic             ce,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
`ifdef QUAD_VELOCITY_EN
    output logic             err,
    output logic [7:0]       vel
`else
    output logic             err
`endif
);

    // Accumulator holds |acc| < 2^DIV_SHIFT; the sum needs one extra bit so
    // the threshold itself is representable before it is consumed.
    localparam int ACC_W = DIV_SHIFT + 1;
    localparam int SUM_W = DIV_SHIFT + 2;
    localparam logic signed [SUM_W-1:0] SUM_ONE  = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SUM_MONE = {SUM_W{1'b1}};
    localparam logic signed [SUM_W-1:0] ACC_POS  = SUM_W'(2 ** DIV_SHIFT);
    localparam logic signed [SUM_W-1:0] ACC_NEG  = -ACC_POS;

    quad_phase_t phase_prev, phase_new;
    logic        upd;
    quad_dec_t   dec;

    logic [CNT_W-1:0]        count_q, count_d;
    logic                    dir_q, dir_d;
    logic                    step_q, step_d;
    logic                    err_q, err_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [SUM_W-1:0] acc_base, acc_sum;

    quad_glitch_filter #(
        .W        (2),
        .FILT_LEN (FILT_LEN),
        .RST_VAL  (PHASE_IDLE)
    ) u_filt (
        .clk      (clk_12m),
        .rst      (reset),
        .ce       (ce),
        .din      ({enc_a, enc_b}),
        .filt     (phase_prev),
        .sync_val (phase_new),
        .upd      (upd)
    );

    always_ff @(posedge clk_12m or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        dec      = quad_dir(phase_prev, phase_new);
        count_d  = count_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        err_d    = 1'b0;
        acc_d    = acc_q;
        acc_base = {acc_q[ACC_W-1], acc_q};
        acc_sum  = acc_base;
        if (ce && upd) begin
            if (dec.illegal) begin
                err_d = 1'b1;
                acc_d = '0;
            end else if (dec.valid) begin
                // Non-zero accumulator of the opposite sign = reversal.
                if (acc_q != '0 && acc_q[ACC_W-1] == dec.inc)
                    acc_base = '0;
                acc_sum = acc_base + (dec.inc ? SUM_ONE : SUM_MONE);
                if (acc_sum == ACC_POS || acc_sum == ACC_NEG) begin
                    count_d = dec.inc ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
                    dir_d   = dec.inc;
                    step_d  = 1'b1;
                    acc_d   = '0;
                end else begin
                    acc_d = acc_sum[ACC_W-1:0];
                end
            end
        end
        // Clear wins over a simultaneous step for count, but step/dir stand.
        if (clr) begin
            count_d = '0;
            acc_d   = '0;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign err   = err_q;

`ifdef QUAD_VELOCITY_EN
    logic [15:0]       win_q, win_d;
    logic signed [7:0] tally_q, tally_d, tally_nx;
    logic signed [7:0] vel_q, vel_d;

    always_ff @(posedge clk_12m or posedge reset) begin
        if (reset) begin
            win_q   <= '0;
            tally_q <= '0;
            vel_q   <= '0;
        end else begin
            win_q   <= win_d;
            tally_q <= tally_d;
            vel_q   <= vel_d;
        end
    end

    always_comb begin
        win_d    = win_q;
        tally_d  = tally_q;
        vel_d    = vel_q;
        tally_nx = tally_q;
        if (step_d) begin
            if (dir_d && tally_q != 8'sd127)
                tally_nx = tally_q + 8'sd1;
            else if (!dir_d && tally_q != -8'sd128)
                tally_nx = tally_q - 8'sd1;
        end
        if (ce) begin
            win_d = win_q + 16'd1;
            if (win_q == 16'hFFFF) begin
                vel_d   = tally_nx;
                tally_d = '0;
            end else begin
                tally_d = tally_nx;
            end
        end
        if (clr)
            tally_d = '0;
    end

    assign vel = vel_q;
`endif

endmodule

// File: tb/tb_spinner_quad_decoder.sv
module tb_spinner_quad_decoder;

    logic       clk = 1'b0;
    logic       reset, ce, enc_a, enc_b, clr;
    logic [7:0] count0, count1;
    logic       dir0, step0, err0, dir1, step1, err1;

    int checks = 0;
    int errors = 0;
    int st0, er0, st1, er1;

    always #5 clk = ~clk;

    spinner_quad_decoder #(.CNT_W(8), .FILT_LEN(3), .DIV_SHIFT(0)) dut0 (
        .clk_12m(clk), .reset(reset), .ce(ce), .enc_a(enc_a), .enc_b(enc_b),
        .clr(clr), .count(count0), .dir(dir0), .step(step0), .err(err0)
    );

    spinner_quad_decoder #(.CNT_W(8), .FILT_LEN(3), .DIV_SHIFT(1)) dut1 (
        .clk_12m(clk), .reset(reset), .ce(ce), .enc_a(enc_a), .enc_b(enc_b),
        .clr(clr), .count(count1), .dir(dir1), .step(step1), .err(err1)
    );

    // Drive phase {enc_a,enc_b}, then run n cycles tallying output pulses.
    task automatic hold(input logic [1:0] p, input int n);
        {enc_a, enc_b} = p;
        repeat (n) begin
            @(negedge clk);
            if (step0) st0++;
            if (err0)  er0++;
            if (step1) st1++;
            if (err1)  er1++;
        end
    endtask

    task automatic clear_tally();
        st0 = 0; er0 = 0; st1 = 0; er1 = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ce = 1'b1; clr = 1'b0; {enc_a, enc_b} = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if ({count0, dir0, step0, err0} !== 11'h0) begin
            errors++;
            $display("FAIL reset_dut0: got cnt=%0h dir=%0b step=%0b err=%0b, want all 0",
                     count0, dir0, step0, err0);
        end
        checks++;
        if ({count1, dir1, step1, err1} !== 11'h0) begin
            errors++;
            $display("FAIL reset_dut1: got cnt=%0h dir=%0b step=%0b err=%0b, want all 0",
                     count1, dir1, step1, err1);
        end
        reset = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // 11->10->00->01->11 steps down from 0x00 through the wrap.
    task automatic test_decrement();
        logic [1:0] ph [4]  = '{2'b10, 2'b00, 2'b01, 2'b11};
        logic [7:0] exp [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
        clear_tally();
        for (int i = 0; i < 4; i++) begin
            hold(ph[i], 10);
            checks++;
            if (count0 !== exp[i]) begin
                errors++;
                $display("FAIL dec_count[%0d]: got %0h want %0h", i, count0, exp[i]);
            end
        end
        checks++;
        if (st0 !== 4 || er0 !== 0 || dir0 !== 1'b0) begin
            errors++;
            $display("FAIL dec_summary: got steps=%0d errs=%0d dir=%0b want 4 0 0", st0, er0, dir0);
        end
    endtask

    // 11->01->00->10->11->01->00 steps up, wrapping 0xFF -> 0x00.
    task automatic test_increment_wrap();
        logic [1:0] ph [6]  = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        logic [7:0] exp [6] = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        clear_tally();
        for (int i = 0; i < 6; i++) begin
            hold(ph[i], 10);
            checks++;
            if (count0 !== exp[i]) begin
                errors++;
                $display("FAIL inc_count[%0d]: got %0h want %0h", i, count0, exp[i]);
            end
        end
        checks++;
        if (st0 !== 6 || er0 !== 0 || dir0 !== 1'b1) begin
            errors++;
            $display("FAIL inc_summary: got steps=%0d errs=%0d dir=%0b want 6 0 1", st0, er0, dir0);
        end
    endtask

    task automatic test_glitch_latency();
        int lat;
        clear_tally();
        // 2-clk glitch on enc_a from phase 00 must be filtered out.
        hold(2'b10, 2);
        hold(2'b00, 12);
        checks++;
        if (st0 !== 0 || er0 !== 0 || count0 !== 8'h02) begin
            errors++;
            $display("FAIL glitch: got steps=%0d errs=%0d cnt=%0h want 0 0 02", st0, er0, count0);
        end
        // Held change 00->10: step appears 2 sync + 3 filter + 1 clk later.
        {enc_a, enc_b} = 2'b10;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (step0 && lat < 0) lat = k;
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL latency: got %0d clk want 6", lat);
        end
        checks++;
        if (count0 !== 8'h03) begin
            errors++;
            $display("FAIL latency_count: got %0h want 03", count0);
        end
    endtask

    task automatic test_illegal();
        hold(2'b11, 10);       // 10->11 up: 0x04
        clear_tally();
        hold(2'b00, 10);       // 11->00 both bits
        checks++;
        if (er0 !== 1 || st0 !== 0 || count0 !== 8'h04) begin
            errors++;
            $display("FAIL illegal: got errs=%0d steps=%0d cnt=%0h want 1 0 04", er0, st0, count0);
        end
        clear_tally();
        hold(2'b10, 10);       // 00->10 up: 0x05
        checks++;
        if (er0 !== 0 || st0 !== 1 || count0 !== 8'h05) begin
            errors++;
            $display("FAIL after_illegal: got errs=%0d steps=%0d cnt=%0h want 0 1 05", er0, st0, count0);
        end
    endtask

    task automatic test_ce_hold();
        clear_tally();
        ce = 1'b0;
        hold(2'b11, 20);
        checks++;
        if (st0 !== 0 || count0 !== 8'h05) begin
            errors++;
            $display("FAIL ce_low: got steps=%0d cnt=%0h want 0 05", st0, count0);
        end
        ce = 1'b1;
        hold(2'b11, 10);
        checks++;
        if (st0 !== 1 || count0 !== 8'h06) begin
            errors++;
            $display("FAIL ce_resume: got steps=%0d cnt=%0h want 1 06", st0, count0);
        end
    endtask

    task automatic test_divider();
        reset = 1'b1; {enc_a, enc_b} = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        clear_tally();
        hold(2'b01, 10); hold(2'b00, 10); hold(2'b10, 10); hold(2'b11, 10);
        checks++;
        if (count1 !== 8'h02 || st1 !== 2 || dir1 !== 1'b1) begin
            errors++;
            $display("FAIL div_inc: got cnt=%0h steps=%0d dir=%0b want 02 2 1", count1, st1, dir1);
        end
        clear_tally();
        // inc, dec, dec: reversal discards the lone inc, two decs count once.
        hold(2'b01, 10); hold(2'b11, 10); hold(2'b10, 10);
        checks++;
        if (count1 !== 8'h01 || st1 !== 1 || dir1 !== 1'b0) begin
            errors++;
            $display("FAIL div_rev: got cnt=%0h steps=%0d dir=%0b want 01 1 0", count1, st1, dir1);
        end
    endtask

    task automatic test_clr_step();
        reset = 1'b1; {enc_a, enc_b} = 2'b11;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            hold(2'b01, 7); hold(2'b00, 7); hold(2'b10, 7); hold(2'b11, 7);
        end
        checks++;
        if (count0 !== 8'h10) begin
            errors++;
            $display("FAIL clr_setup: got %0h want 10", count0);
        end
        {enc_a, enc_b} = 2'b01;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (step0 !== 1'b1 || count0 !== 8'h00 || dir0 !== 1'b1) begin
            errors++;
            $display("FAIL clr_step: got step=%0b cnt=%0h dir=%0b want 1 00 1", step0, count0, dir0);
        end
        clear_tally();
        hold(2'b01, 10);
        checks++;
        if (count0 !== 8'h00 || st0 !== 0) begin
            errors++;
            $display("FAIL clr_after: got cnt=%0h steps=%0d want 00 0", count0, st0);
        end
    endtask

    task automatic test_reset_mid();
        hold(2'b00, 10);       // 01->00 up: 0x01
        {enc_a, enc_b} = 2'b10;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        {enc_a, enc_b} = 2'b00;
        repeat (2) @(negedge clk);
        checks++;
        if ({count0, dir0, step0, err0} !== 11'h0) begin
            errors++;
            $display("FAIL reset_mid: got cnt=%0h dir=%0b step=%0b err=%0b want all 0",
                     count0, dir0, step0, err0);
        end
        reset = 1'b0;
        clear_tally();
        // Decoder restarts from 11, so a held 00 reads as an illegal jump.
        hold(2'b00, 15);
        checks++;
        if (er0 !== 1 || st0 !== 0 || count0 !== 8'h00) begin
            errors++;
            $display("FAIL reset_resume: got errs=%0d steps=%0d cnt=%0h want 1 0 00", er0, st0, count0);
        end
    endtask

    initial begin
        test_reset();
        test_decrement();
        test_increment_wrap();
        test_glitch_latency();
        test_illegal();
        test_ce_hold();
        test_divider();
        test_clr_step();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
